// File: rtl/rvc_pkg.sv
// Shared RVC definitions for the packer (write side) and the fetch-side decompressor.
package rvc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned HLEN = 16;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [HLEN-1:0] C_NOP = 16'h0001;

  // Register reachable through a 3-bit compressed specifier (x8-x15).
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

  // 12-bit immediate representable as a 6-bit signed field.
  function automatic logic fits_s6(input logic [11:0] v);
    return v[11:5] == {7{v[5]}};
  endfunction

endpackage

// File: rtl/rvc_compress.sv
// Combinational RV32I -> RVC re-encoder; only exact equivalents are compressed.
// Define RVC_PACK_SP_EN to also emit the stack-pointer forms (LWSP/SWSP/ADDI16SP/ADDI4SPN).
module rvc_compress
  import rvc_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic            is_c,
  output logic [HLEN-1:0] c16
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [19:0] imm_u;
  logic        ca_ok;
  logic [1:0]  ca_op;

  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_u = instr[31:12];

  // Register-register ALU ops in the CA format (rd == rs1, both compressed regs).
  always_comb begin
    ca_ok = 1'b0;
    ca_op = 2'b00;
    if (rd == rs1 && is_creg(rd) && is_creg(rs2)) begin
      if (f7 == F7_ALT && f3 == F3_ADD) begin
        ca_ok = 1'b1; ca_op = 2'b00;
      end else if (f7 == F7_BASE && f3 == F3_XOR) begin
        ca_ok = 1'b1; ca_op = 2'b01;
      end else if (f7 == F7_BASE && f3 == F3_OR) begin
        ca_ok = 1'b1; ca_op = 2'b10;
      end else if (f7 == F7_BASE && f3 == F3_AND) begin
        ca_ok = 1'b1; ca_op = 2'b11;
      end
    end
  end

  always_comb begin
    is_c = 1'b0;
    c16  = '0;
    case (opc)
      OPC_OP_IMM: begin
        case (f3)
          F3_ADD: begin
            if (rd != 5'd0 && rs1 == 5'd0 && fits_s6(imm_i)) begin
              is_c = 1'b1;
              c16  = {3'b010, imm_i[5], rd, imm_i[4:0], Q1};
            end else if (rd != 5'd0 && rd == rs1 && imm_i != 12'd0 && fits_s6(imm_i)) begin
              is_c = 1'b1;
              c16  = {3'b000, imm_i[5], rd, imm_i[4:0], Q1};
            end
`ifdef RVC_PACK_SP_EN
            else if (rd == 5'd2 && rs1 == 5'd2 && imm_i != 12'd0 && imm_i[3:0] == 4'd0 &&
                     imm_i[11:9] == {3{imm_i[9]}}) begin
              is_c = 1'b1;
              c16  = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], Q1};
            end else if (rs1 == 5'd2 && is_creg(rd) && imm_i != 12'd0 &&
                         imm_i[11:10] == 2'd0 && imm_i[1:0] == 2'd0) begin
              is_c = 1'b1;
              c16  = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], Q0};
            end
`endif
          end
          F3_SLL: begin
            if (f7 == F7_BASE && rd != 5'd0 && rd == rs1 && rs2 != 5'd0) begin
              is_c = 1'b1;
              c16  = {3'b000, 1'b0, rd, rs2, Q2};
            end
          end
          F3_SR: begin
            if ((f7 == F7_BASE || f7 == F7_ALT) && is_creg(rd) && rd == rs1 && rs2 != 5'd0) begin
              is_c = 1'b1;
              c16  = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, Q1};
            end
          end
          F3_AND: begin
            if (is_creg(rd) && rd == rs1 && fits_s6(imm_i)) begin
              is_c = 1'b1;
              c16  = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], Q1};
            end
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        if (rd != 5'd0 && rd != 5'd2 && imm_u != 20'd0 && imm_u[19:5] == {15{imm_u[5]}}) begin
          is_c = 1'b1;
          c16  = {3'b011, imm_u[5], rd, imm_u[4:0], Q1};
        end
      end
      OPC_OP: begin
        if (f7 == F7_BASE && f3 == F3_ADD && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
          is_c = 1'b1;
          c16  = {4'b1000, rd, rs2, Q2};
        end else if (f7 == F7_BASE && f3 == F3_ADD && rd != 5'd0 && rs2 != 5'd0 && rd == rs1) begin
          is_c = 1'b1;
          c16  = {4'b1001, rd, rs2, Q2};
        end else if (ca_ok) begin
          is_c = 1'b1;
          c16  = {6'b100011, rd[2:0], ca_op, rs2[2:0], Q1};
        end
      end
      OPC_LOAD: begin
        if (f3 == F3_LW) begin
          if (is_creg(rd) && is_creg(rs1) && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0) begin
            is_c = 1'b1;
            c16  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], Q0};
          end
`ifdef RVC_PACK_SP_EN
          else if (rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'd0) begin
            is_c = 1'b1;
            c16  = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], Q2};
          end
`endif
        end
      end
      OPC_STORE: begin
        if (f3 == F3_LW) begin
          if (is_creg(rs2) && is_creg(rs1) && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0) begin
            is_c = 1'b1;
            c16  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], Q0};
          end
`ifdef RVC_PACK_SP_EN
          else if (rs1 == 5'd2 && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'd0) begin
            is_c = 1'b1;
            c16  = {3'b110, imm_s[5:2], imm_s[7:6], rs2, Q2};
          end
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvc_packer.sv
// Packs a mixed 16/32-bit RVC stream into aligned little-endian 32-bit words.
// Optional SP-relative compression is enabled inside rvc_compress by RVC_PACK_SP_EN.
module rvc_packer
  import rvc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic            flush,
  output logic            flush_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_word,
  output logic [15:0]     comp_count,
  output logic            err
);

  logic            is_c;
  logic [HLEN-1:0] c16;

  logic [HLEN-1:0] half_q, half_d;
  logic            half_v_q, half_v_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            out_v_q, out_v_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            accept;

  rvc_compress u_compress (
    .instr (in_instr),
    .is_c  (is_c),
    .c16   (c16)
  );

  assign in_ready   = !out_v_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_v_q;
  assign out_word   = out_q;
  assign comp_count = cnt_q;
  assign err        = err_q;
  assign flush_done = done_q;

  // Next-state: an accepted input always wins over flush.
  always_comb begin
    half_d   = half_q;
    half_v_d = half_v_q;
    out_d    = out_q;
    out_v_d  = out_v_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;

    if (out_v_q && out_ready) out_v_d = 1'b0;

    if (accept) begin
      if (in_instr[1:0] != 2'b11) err_d = 1'b1;
      if (is_c) begin
        if (cnt_q != 16'hFFFF) cnt_d = 16'(cnt_q + 16'd1);
        if (half_v_q) begin
          out_d    = {c16, half_q};
          out_v_d  = 1'b1;
          half_v_d = 1'b0;
        end else begin
          half_d   = c16;
          half_v_d = 1'b1;
        end
      end else begin
        out_v_d = 1'b1;
        if (half_v_q) begin
          out_d  = {in_instr[15:0], half_q};
          half_d = in_instr[31:16];
        end else begin
          out_d = in_instr;
        end
      end
    end else if (flush) begin
      if (half_v_q && in_ready) begin
        out_d    = {C_NOP, half_q};
        out_v_d  = 1'b1;
        half_v_d = 1'b0;
      end else if (!half_v_q && !out_v_q) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_q   <= '0;
      half_v_q <= 1'b0;
      out_q    <= '0;
      out_v_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      half_q   <= half_d;
      half_v_q <= half_v_d;
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_rvc_packer.sv
// Directed bench for rvc_packer; hand-computed expected words and counters.
module tb_rvc_packer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [15:0] comp_count;
  logic        err;

  int unsigned total;
  int unsigned bad;
  int unsigned exp_cnt;

  rvc_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .comp_count (comp_count),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; exp_cnt = 0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    nxt(); nxt();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_comp_count", 32'(comp_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // addi x8,x8,1 + add x10,x10,x11 -> two C forms in one word
    in_valid = 1'b1; in_instr = 32'h00140413;
    nxt();
    chk("t1_half_no_out", 32'(out_valid), 32'd0);
    in_instr = 32'h00B50533;
    nxt();
    exp_cnt = 2;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", out_word, 32'h952E0405);
    chk("t1_count", 32'(comp_count), 32'(exp_cnt));
    in_valid = 1'b0;
    nxt();
    chk("t1_drained", 32'(out_valid), 32'd0);

    // compressed + jal -> split 32-bit, then flush pads with C.NOP
    in_valid = 1'b1; in_instr = 32'h00140413;
    nxt();
    in_instr = 32'h000000EF;
    nxt();
    exp_cnt = 3;
    chk("t2_word", out_word, 32'h00EF0405);
    chk("t2_count", 32'(comp_count), 32'(exp_cnt));
    in_valid = 1'b0; flush = 1'b1;
    nxt();
    chk("t2_pad_valid", 32'(out_valid), 32'd1);
    chk("t2_pad_word", out_word, 32'h00010000);
    chk("t2_done_early", 32'(flush_done), 32'd0);
    nxt();
    chk("t2_pad_gone", 32'(out_valid), 32'd0);
    chk("t2_done_not_yet", 32'(flush_done), 32'd0);
    nxt();
    chk("t2_done", 32'(flush_done), 32'd1);
    flush = 1'b0;
    nxt();
    chk("t2_done_drop", 32'(flush_done), 32'd0);

    // backpressure: li x10,5 twice, then stall 3 cycles with li x11,7 pending
    in_valid = 1'b1; in_instr = 32'h00500513;
    nxt();
    nxt();
    exp_cnt = 5;
    chk("t3_word", out_word, 32'h45154515);
    out_ready = 1'b0; in_instr = 32'h00700593;
    #1;
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("t3_stall_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_word", out_word, 32'h45154515);
      chk("t3_stall_ready", 32'(in_ready), 32'd0);
    end
    chk("t3_stall_count", 32'(comp_count), 32'(exp_cnt));
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_back", 32'(in_ready), 32'd1);
    nxt();
    chk("t3_after_drain", 32'(out_valid), 32'd0);
    in_instr = 32'h00500513;
    nxt();
    exp_cnt = 7;
    chk("t3_resume_word", out_word, 32'h4515459D);
    chk("t3_resume_count", 32'(comp_count), 32'(exp_cnt));

    // sub x8,x8,x9 + sw x9,4(x8) -> C.SUB / C.SW
    in_instr = 32'h40940433;
    nxt();
    in_instr = 32'h00942223;
    nxt();
    exp_cnt = 9;
    chk("t4_word", out_word, 32'hC0448C05);
    chk("t4_count", 32'(comp_count), 32'(exp_cnt));

    // lw x8,0(x2) twice: SP form only with the option
    in_instr = 32'h00012403;
`ifdef RVC_PACK_SP_EN
    nxt();
    chk("t5_half_no_out", 32'(out_valid), 32'd0);
    nxt();
    exp_cnt = 11;
    chk("t5_lwsp_word", out_word, 32'h44024402);
`else
    nxt();
    chk("t5_lw_word1", out_word, 32'h00012403);
    nxt();
    chk("t5_lw_valid2", 32'(out_valid), 32'd1);
    chk("t5_lw_word2", out_word, 32'h00012403);
`endif
    chk("t5_count", 32'(comp_count), 32'(exp_cnt));
    in_valid = 1'b0;
    nxt();

    // illegal-quadrant input passes through 32-bit and sets sticky err
    in_valid = 1'b1; in_instr = 32'h00000001;
    nxt();
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_word", out_word, 32'h00000001);
    in_instr = 32'h000000EF;
    nxt();
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk("t6_word2", out_word, 32'h000000EF);

    // reset while a halfword is held: discarded, no pad
    in_instr = 32'h00140413;
    nxt();
    in_valid = 1'b0; reset = 1'b1;
    nxt();
    reset = 1'b0;
    chk("t7_valid", 32'(out_valid), 32'd0);
    chk("t7_count", 32'(comp_count), 32'd0);
    chk("t7_err", 32'(err), 32'd0);
    nxt();
    chk("t7_no_pad", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_instr = 32'h000000EF;
    nxt();
    chk("t7_clean_word", out_word, 32'h000000EF);
    in_valid = 1'b0;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvc_packer.md
# rvc_packer

Streaming RVC compressor for the instruction-image path, the write-side counterpart of the fetch-side decompressor. It accepts one 32-bit RV32I instruction per handshake and re-encodes it as a 16-bit RVC instruction where an exact equivalent exists. It packs the resulting mixed 16/32-bit stream little-endian into aligned 32-bit memory words, with the lower halfword holding the lower address. It sits between the program loader and instruction-memory write port.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input instruction valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_instr  in  32  uncompressed RV32I instruction
- flush  in  1  level request: drain any held halfword, padded with C.NOP
- flush_done  out  1  one-cycle pulse, no halfword held and output register empty
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_word  out  32  packed word; [15:0] = earlier halfword
- comp_count  out  16  number of instructions compressed, saturating at 16'hFFFF
- err  out  1  sticky: an input with in_instr[1:0] != 2'b11 was received

## Operation
- Holding state: half_q[15:0] and half_v, a registered output slot out_q/out_valid, and comp_count/err.
- Compression is combinational on in_instr and yields c16 plus an is_c flag. Control-flow instructions are never compressed: JAL, JALR, branches, AUIPC, ECALL, EBREAK.
- Compressed forms, exact equivalence only:
  - C.ADDI, C.LI, C.LUI (rd≠x0,x2; nonzero imm), C.MV, C.ADD, C.SLLI
  - C.SUB, C.XOR, C.OR, C.AND (rd=rs1, both in x8–x15)
  - C.ANDI, C.SRLI, C.SRAI
  - C.LW and C.SW (x8–x15, word-aligned offset 0–124)
- On an accepted input:
  - is_c, !half_v: half_q <= c16, half_v <= 1; no output.
  - is_c, half_v: out_q <= {c16, half_q}; half_v <= 0.
  - !is_c, !half_v: out_q <= in_instr.
  - !is_c, half_v: out_q <= {in_instr[15:0], half_q}; half_q <= in_instr[31:16]; half_v stays 1.
- An input with [1:0] != 2'b11 passes as !is_c and sets err.
- comp_count increments by one per accepted is_c input and saturates.
- flush is honoured only in a cycle with no input transfer; an accepted input always takes priority.
  - If half_v and the output slot is free: out_q <= {16'h0001, half_q}, half_v <= 0.
  - If !half_v and !out_valid: pulse flush_done.

## Timing
- Reset values: in_ready 1, out_valid 0, out_word 0, flush_done 0, comp_count 0, err 0, half_v 0.
- in_ready = !out_valid || out_ready; the block is combinationally dependent on out_ready, with no skid buffer.
- Latency: out_valid rises one cycle after the accepting edge that completes a word.
- out_word is stable while out_valid && !out_ready.
- Sustained throughput is one input per cycle when out_ready is held high.
- flush_done asserts at least one cycle after the pad word is accepted. With flush held, flush_done pulses every idle cycle.
- Reset mid-operation discards the held halfword and the pending output word, with no pad emitted.

## Configuration
- RVC_PACK_SP_EN defined: additionally compresses to C.LWSP, C.SWSP (rs1=x2, word-aligned offset 0–252) and C.ADDI16SP, C.ADDI4SPN.
- RVC_PACK_SP_EN undefined: these instructions pass uncompressed. All other behaviour is identical.

## Structure
- Shared package rvc_pkg holds:
  - opcode, funct3 and quadrant localparams
  - C_NOP = 16'h0001
  - the compressed-register-range helper function
- The package is shared with the decompressor.
- One sub-module, rvc_compress: purely combinational in_instr -> {is_c, c16}. It contains the RVC_PACK_SP_EN ifdef.
- rvc_packer holds the packing registers, handshake and counters.

## Test plan
- addi x8,x8,1 (0x00140413) then add x10,x10,x11 (0x00B50533) -> out_word 0x952E0405, comp_count 2.
- 0x00140413 then jal x1,0 (0x000000EF) -> out_word 0x00EF0405; half 0x0000 held; then flush -> 0x00010000, followed by flush_done.
- 0x00500513 with out_ready=0 for 3 cycles after a full word -> in_ready 0, out_word stable, no loss; stream resumes when out_ready returns high.
- Build without RVC_PACK_SP_EN: lw x8,0(x2) (0x00012403) twice -> two uncompressed words. Build with it: C.LWSP 0x4402 packed as 0x44024402.
- Input 0x00000001 -> err=1 sticky; passed as 32-bit; reset clears err.
- Reset asserted while half_v=1 -> no output word; out_valid=0, comp_count=0 the cycle after reset.
